// File: rtl/ahb_ram_slave_if.sv
// Simplified AHB-lite data bus between an initiator and a RAM responder.
// Address-phase controls, data-phase write data and the slave response.
interface ahb_ram_slave_if;
   logic        htrans;
   logic [31:0] haddr;
   logic        hwrite;
   logic [1:0]  hsize;
   logic        hprot;
   logic [31:0] hwdata;
   logic [31:0] hrdata;
   logic        hready;
   logic        hresp;

   modport master (
      output htrans, haddr, hwrite, hsize, hprot, hwdata,
      input  hrdata, hready, hresp
   );

   modport slave (
      input  htrans, haddr, hwrite, hsize, hprot, hwdata,
      output hrdata, hready, hresp
   );
endinterface

// File: rtl/ahb_ram_slave.sv
// Single-port RAM responder for the AHB-lite data bus.
// Pipelined transfers, configurable wait states, two-cycle ERROR.
module ahb_ram_slave #(
   parameter int DEPTH_LOG2 = 10,
   parameter int WAIT       = 0,
   parameter bit EXEC_EN    = 1'b1
) (
   input logic            clk,
   input logic            rstn,
   ahb_ram_slave_if.slave bus
);
   localparam int AW    = DEPTH_LOG2 + 2;
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [2:0] WAIT_N = 3'(WAIT);

   typedef enum logic [2:0] {
      IDLE, WAITST, OKAY, ERR1, ERR2
   } state_t;

   state_t          state, state_nx;
   logic [2:0]      cnt;
   logic [AW-1:0]   a_addr;
   logic            a_write;
   logic [1:0]      a_size;
   logic [31:0]     mem [DEPTH];
   logic [31:0]     rd_ram;
   logic [31:0]     rd_word;
   logic [31:0]     rd_hold;
   logic [31:0]     fwd_data;
   logic [3:0]      fwd_be;
   logic [3:0]      be;
   logic            accept;
   logic            bad_in;
   logic            we;
   logic            re;
   logic            match;

   assign accept = bus.htrans & bus.hready;
   assign we     = (state == OKAY) & a_write;
   assign re     = accept & ~bus.hwrite & ~bad_in;
   assign match  = we & (a_addr[AW-1:2] == bus.haddr[AW-1:2]);

   // classify the address phase as legal or ERROR
   always_comb begin
      bad_in = 1'b0;
      if (bus.haddr[31:AW] != '0)
         bad_in = 1'b1;
      if (bus.hsize == 2'd3)
         bad_in = 1'b1;
      if (bus.hsize == 2'd1 && bus.haddr[0])
         bad_in = 1'b1;
      if (bus.hsize == 2'd2 && bus.haddr[1:0] != 2'b00)
         bad_in = 1'b1;
      if (!bus.hprot && !EXEC_EN)
         bad_in = 1'b1;
   end

   // byte lanes of the registered write
   always_comb begin
      be = 4'b0000;
      unique case (a_size)
         2'd0:    be = 4'b0001 << a_addr[1:0];
         2'd1:    be = a_addr[1] ? 4'b1100 : 4'b0011;
         2'd2:    be = 4'b1111;
         default: be = 4'b0000;
      endcase
   end

   // state register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // next-state logic
   always_comb begin
      state_nx = state;
      unique case (state)
         WAITST: if (cnt == 3'd1) state_nx = OKAY;
         ERR1:   state_nx = ERR2;
         default: begin
            if (!accept)
               state_nx = IDLE;
            else if (bad_in)
               state_nx = ERR1;
            else if (WAIT_N != 3'd0)
               state_nx = WAITST;
            else
               state_nx = OKAY;
         end
      endcase
   end

   // bus response; read data only changes in a read completion cycle
   always_comb begin
      bus.hready = !(state == WAITST || state == ERR1);
      bus.hresp  = (state == ERR1 || state == ERR2);
      bus.hrdata = rd_hold;
      if (state == OKAY && !a_write)
         bus.hrdata = rd_word;
   end

   // address-phase capture, wait counter, forwarding and read hold
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         a_addr   <= '0;
         a_write  <= 1'b0;
         a_size   <= 2'd0;
         cnt      <= 3'd0;
         fwd_be   <= 4'b0000;
         fwd_data <= '0;
         rd_hold  <= '0;
      end else begin
         if (accept) begin
            a_addr  <= bus.haddr[AW-1:0];
            a_write <= bus.hwrite;
            a_size  <= bus.hsize;
            cnt     <= bad_in ? 3'd0 : WAIT_N;
         end else if (state == WAITST) begin
            cnt <= cnt - 3'd1;
         end
         if (re) begin
            fwd_be   <= match ? be : 4'b0000;
            fwd_data <= bus.hwdata;
         end
         if (state == OKAY && !a_write)
            rd_hold <= rd_word;
      end
   end

   // synchronous RAM: lane-enabled write at completion, read at acceptance
   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < 4; i++)
            if (be[i])
               mem[a_addr[AW-1:2]][8*i +: 8] <= bus.hwdata[8*i +: 8];
      end
      if (re)
         rd_ram <= mem[bus.haddr[AW-1:2]];
   end

   // merge bytes written on the same edge the read was issued
   always_comb begin
      rd_word = rd_ram;
      for (int i = 0; i < 4; i++)
         if (fwd_be[i])
            rd_word[8*i +: 8] = fwd_data[8*i +: 8];
   end
endmodule

// File: tb/tb_ahb_ram_slave.sv
// Directed bench for ahb_ram_slave: zero-wait table plus
// hand sequences for wait states, fetch errors and async reset.
module tb_ahb_ram_slave;
   logic clk;
   logic rstn;
   int   total;
   int   bad;

   ahb_ram_slave_if bus0 ();
   ahb_ram_slave_if bus3 ();

   ahb_ram_slave #(
      .DEPTH_LOG2(10), .WAIT(0), .EXEC_EN(1'b1)
   ) u0 (
      .clk (clk),
      .rstn(rstn),
      .bus (bus0)
   );

   ahb_ram_slave #(
      .DEPTH_LOG2(10), .WAIT(3), .EXEC_EN(1'b0)
   ) u3 (
      .clk (clk),
      .rstn(rstn),
      .bus (bus3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        tr;
      logic [31:0] addr;
      logic        wr;
      logic [1:0]  sz;
      logic        prot;
      logic [31:0] wd;
      logic        rdy;
      logic        rsp;
      logic [31:0] rd;
   } vec_t;

   vec_t v [22];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic aph3(input logic tr, input logic [31:0] a,
                       input logic wr, input logic [1:0] sz,
                       input logic prot);
      bus3.htrans = tr;
      bus3.haddr  = a;
      bus3.hwrite = wr;
      bus3.hsize  = sz;
      bus3.hprot  = prot;
   endtask

   task automatic chk3(input string name, input logic rdy,
                       input logic rsp);
      chk({name, ".hready"}, 32'(bus3.hready), 32'(rdy));
      chk({name, ".hresp"},  32'(bus3.hresp),  32'(rsp));
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rstn  = 1'b0;
      bus0.htrans = 1'b0; bus0.haddr = '0; bus0.hwrite = 1'b0;
      bus0.hsize  = 2'd0; bus0.hprot = 1'b1; bus0.hwdata = '0;
      bus3.htrans = 1'b0; bus3.haddr = '0; bus3.hwrite = 1'b0;
      bus3.hsize  = 2'd0; bus3.hprot = 1'b1; bus3.hwdata = '0;

      //        tr addr          wr sz   pr wdata          rdy rsp rdata
      v[0]  = '{1, 32'h10,       1, 2'd2, 1, 32'h0,        1, 0, 32'h0};
      v[1]  = '{0, 32'h0,        0, 2'd0, 1, 32'hA5A51234, 1, 0, 32'h0};
      v[2]  = '{1, 32'h10,       0, 2'd2, 1, 32'h0,        1, 0, 32'h0};
      v[3]  = '{1, 32'h10,       1, 2'd2, 1, 32'h0,        1, 0, 32'hA5A51234};
      v[4]  = '{1, 32'h13,       1, 2'd0, 1, 32'h11223344, 1, 0, 32'hA5A51234};
      v[5]  = '{0, 32'h0,        0, 2'd0, 1, 32'hEE998877, 1, 0, 32'hA5A51234};
      v[6]  = '{1, 32'h10,       0, 2'd1, 1, 32'h0,        1, 0, 32'hA5A51234};
      v[7]  = '{1, 32'h40,       1, 2'd2, 1, 32'h0,        1, 0, 32'hEE223344};
      v[8]  = '{1, 32'h40,       0, 2'd2, 1, 32'hCAFEF00D, 1, 0, 32'hEE223344};
      v[9]  = '{1, 32'h1000,     0, 2'd2, 1, 32'h0,        1, 0, 32'hCAFEF00D};
      v[10] = '{1, 32'h10,       0, 2'd2, 1, 32'h0,        0, 1, 32'hCAFEF00D};
      v[11] = '{1, 32'h42,       0, 2'd2, 1, 32'h0,        1, 1, 32'hCAFEF00D};
      v[12] = '{0, 32'h0,        0, 2'd0, 1, 32'h0,        0, 1, 32'hCAFEF00D};
      v[13] = '{1, 32'h41,       1, 2'd1, 1, 32'h0,        1, 1, 32'hCAFEF00D};
      v[14] = '{0, 32'h0,        0, 2'd0, 1, 32'hFFFFFFFF, 0, 1, 32'hCAFEF00D};
      v[15] = '{1, 32'h40,       0, 2'd2, 1, 32'hFFFFFFFF, 1, 1, 32'hCAFEF00D};
      v[16] = '{1, 32'h10,       0, 2'd2, 0, 32'h0,        1, 0, 32'hCAFEF00D};
      v[17] = '{0, 32'h0,        0, 2'd0, 1, 32'h0,        1, 0, 32'hEE223344};
      v[18] = '{1, 32'h0,        0, 2'd3, 1, 32'h0,        1, 0, 32'hEE223344};
      v[19] = '{0, 32'h0,        0, 2'd0, 1, 32'h0,        0, 1, 32'hEE223344};
      v[20] = '{0, 32'h0,        0, 2'd0, 1, 32'h0,        1, 1, 32'hEE223344};
      v[21] = '{0, 32'h0,        0, 2'd0, 1, 32'h0,        1, 0, 32'hEE223344};

      repeat (2) step();
      rstn = 1'b1;
      step();

      // zero-wait table: outputs of each cycle, then next address phase
      for (int i = 0; i < 22; i++) begin
         chk($sformatf("v%0d.hready", i), 32'(bus0.hready), 32'(v[i].rdy));
         chk($sformatf("v%0d.hresp", i),  32'(bus0.hresp),  32'(v[i].rsp));
         chk($sformatf("v%0d.hrdata", i), bus0.hrdata, v[i].rd);
         bus0.htrans = v[i].tr;
         bus0.haddr  = v[i].addr;
         bus0.hwrite = v[i].wr;
         bus0.hsize  = v[i].sz;
         bus0.hprot  = v[i].prot;
         bus0.hwdata = v[i].wd;
         step();
      end

      // WAIT=3: write word 0x8
      chk3("w3.idle", 1'b1, 1'b0);
      chk("w3.rst_rdata", bus3.hrdata, 32'h0);
      aph3(1'b1, 32'h8, 1'b1, 2'd2, 1'b1);
      step();
      aph3(1'b0, 32'h0, 1'b0, 2'd0, 1'b1);
      bus3.hwdata = 32'h13579BDF;
      for (int i = 0; i < 3; i++) begin
         chk3($sformatf("w3.wr_wait%0d", i), 1'b0, 1'b0);
         step();
      end
      chk3("w3.wr_okay", 1'b1, 1'b0);

      // read 0x8; a held address during waits must be ignored
      aph3(1'b1, 32'h8, 1'b0, 2'd2, 1'b1);
      step();
      bus3.hwdata = 32'h0;
      for (int i = 0; i < 3; i++) begin
         chk3($sformatf("w3.rd_wait%0d", i), 1'b0, 1'b0);
         step();
      end
      chk3("w3.rd_okay", 1'b1, 1'b0);
      chk("w3.rd_data", bus3.hrdata, 32'h13579BDF);

      // fetch with execution disabled: two-cycle error, no waits
      aph3(1'b1, 32'h8, 1'b0, 2'd2, 1'b0);
      step();
      aph3(1'b0, 32'h0, 1'b0, 2'd0, 1'b1);
      chk3("w3.err1", 1'b0, 1'b1);
      step();
      chk3("w3.err2", 1'b1, 1'b1);
      step();
      chk3("w3.after_err", 1'b1, 1'b0);
      chk("w3.hold", bus3.hrdata, 32'h13579BDF);

      // reset mid-write during wait states
      aph3(1'b1, 32'h8, 1'b1, 2'd2, 1'b1);
      step();
      aph3(1'b0, 32'h0, 1'b0, 2'd0, 1'b1);
      bus3.hwdata = 32'hDEADBEEF;
      chk3("w3.pre_rst_wait", 1'b0, 1'b0);
      step();
      #2 rstn = 1'b0;
      #1;
      chk3("w3.in_rst", 1'b1, 1'b0);
      chk("w3.rst_hrdata", bus3.hrdata, 32'h0);
      chk("w0.rst_hrdata", bus0.hrdata, 32'h0);
      repeat (2) @(posedge clk);
      #4 rstn = 1'b1;
      step();
      aph3(1'b1, 32'h8, 1'b0, 2'd2, 1'b1);
      step();
      aph3(1'b0, 32'h0, 1'b0, 2'd0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         chk3($sformatf("w3.post_wait%0d", i), 1'b0, 1'b0);
         step();
      end
      chk3("w3.post_okay", 1'b1, 1'b0);
      chk("w3.post_data", bus3.hrdata, 32'h13579BDF);
      step();
      chk3("w3.post_idle", 1'b1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
